water_dispense_controller: RTL and testbench
============================================

// Module: water_dispense_controller
// PURPOSE
//   Downstream stage of water_dispenser: takes the confirmed total amount (units) on a start
//   strobe and drives the pump valve for amount * CYCLES_PER_UNIT clock cycles after a fixed
//   valve settle time. Supports mid-pour cancel, reports remaining units and a done/aborted
//   status. Sits between the dispenser's amount/OK logic and the valve driver pin.
// PARAMETERS
//   AMOUNT_WIDTH     32   width of amount / remaining (matches integer total_amount)
//   MAX_AMOUNT       99   amounts above this are clamped to MAX_AMOUNT at latch time
//   CYCLES_PER_UNIT  50   clock cycles of open valve per dispensed unit (>=1)
//   SETTLE_CYCLES    2    cycles valve is open before unit counting starts (>=1)
// PORTS
//   clock      in   1             system clock, all logic on rising edge
//   reset      in   1             asynchronous, active-high; clears all state
//   amount     in   AMOUNT_WIDTH  unsigned units to pour, sampled only when start accepted
//   start      in   1             one-cycle active-high request (from OK press)
//   cancel     in   1             one-cycle active-high abort (from cancel press)
//   valve_open out  1             registered valve drive
//   busy       out  1             high while a pour is in progress (incl. FINISH)
//   remaining  out  AMOUNT_WIDTH  units still to pour
//   done       out  1             one-cycle pulse at end of every accepted request
//   aborted    out  1             sticky: last request ended by cancel; cleared on next accept
// BEHAVIOUR
//   Reset: state=IDLE, valve_open=0, busy=0, remaining=0, done=0, aborted=0, timers=0.
//   FSM states: IDLE, SETTLE, POUR, FINISH.
//   IDLE: start=1 & cancel=0 & amount>0 -> latch remaining=min(amount,MAX_AMOUNT),
//     aborted=0, valve_open=1, busy=1, settle timer=SETTLE_CYCLES-1, go SETTLE.
//     start=1 & amount==0 -> go FINISH (valve stays 0, busy=1 for FINISH cycle only).
//     start & cancel in same cycle -> ignored, stay IDLE. cancel alone in IDLE -> no effect.
//   SETTLE: count down; at 0 load unit timer=CYCLES_PER_UNIT-1, go POUR.
//   POUR: unit timer counts down; at 0 remaining decrements by 1 and timer reloads;
//     when the decrement takes remaining to 0 -> valve_open=0, go FINISH.
//   FINISH: done=1 for exactly this cycle, busy=1; next cycle IDLE, busy=0.
//   cancel in SETTLE or POUR: next edge valve_open=0, aborted=1, remaining holds current value
//     (not decremented even if unit timer hits 0 that cycle; cancel has priority), go FINISH.
//   start while busy: ignored, amount not resampled. cancel in FINISH: ignored.
//   Timing: start sampled at edge N -> valve_open high after edge N; valve high for exactly
//     SETTLE_CYCLES + amount*CYCLES_PER_UNIT cycles; done high the cycle after valve falls.
//   Arithmetic: unsigned compare/clamp; remaining never underflows; timers sized
//     $clog2(max(CYCLES_PER_UNIT,SETTLE_CYCLES)+1).
//   Async reset mid-pour: valve_open drops immediately with reset, no done pulse generated.
// STRUCTURE
//   Shared include water_dispenser_defs.vh: FSM state encodings (2-bit localparams) and
//   default MAX_AMOUNT, shared with water_dispenser.
//   One sub-module: dispense_unit_timer (loadable down-counter, terminal-count pulse,
//   sync load/clear, async reset) used for both settle and per-unit timing.
// TESTING  (bench: CYCLES_PER_UNIT=4, SETTLE_CYCLES=2, MAX_AMOUNT=99)
//   amount=3, start 1 cycle -> valve_open high 14 cycles, remaining 3->2->1->0 every 4 cycles,
//     done 1 cycle after valve falls, aborted=0, busy low cycle after done.
//   amount=0, start -> valve never rises, done pulse next cycle, remaining=0, aborted=0.
//   amount=5, cancel 9 cycles after start -> valve falls next edge, remaining=4, aborted=1,
//     done 1 cycle; next start amount=1 clears aborted, pours 6 cycles.
//   amount=150 -> remaining latches 99; start pulsed again mid-pour with amount=7 -> ignored.
//   cancel on same cycle as unit terminal count (remaining=2) -> remaining stays 2, aborted=1;
//     start+cancel together in IDLE -> no state change.
//   reset asserted mid-POUR -> all outputs 0 immediately, no done; normal pour after release.

Source files
------------

// File: rtl/water_dispense_controller_pkg.sv
// Shared types and defaults for the water dispense controller.
// FSM encoding, default clamp value and a small sizing helper.
package water_dispense_controller_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    POUR   = 2'd2,
    FINISH = 2'd3
  } state_t;

  localparam int DEFAULT_MAX_AMOUNT = 99;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/water_dispense_controller_if.sv
// Request/status bundle between dispenser logic and the controller.
// master drives the request side, slave is the controller.
interface water_dispense_controller_if #(
  parameter int AMOUNT_WIDTH = 32
);
  logic [AMOUNT_WIDTH-1:0] amount;
  logic                    start;
  logic                    cancel;
  logic                    valve_open;
  logic                    busy;
  logic [AMOUNT_WIDTH-1:0] remaining;
  logic                    done;
  logic                    aborted;

  modport master (
    output amount, start, cancel,
    input  valve_open, busy, remaining, done, aborted
  );

  modport slave (
    input  amount, start, cancel,
    output valve_open, busy, remaining, done, aborted
  );
endinterface

// File: rtl/water_dispense_controller_unit_timer.sv
// Loadable down-counter shared by settle and per-unit timing.
// Clear wins over load; the counter parks at zero.
module dispense_unit_timer #(
  parameter int WIDTH = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             clear,
  input  logic [WIDTH-1:0] value,
  output logic             tc
);
  logic [WIDTH-1:0] count;

  // count down toward zero, synchronous clear/load
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign tc = (count == '0);
endmodule

// File: rtl/water_dispense_controller.sv
// Pour sequencer: settle, then amount * CYCLES_PER_UNIT open-valve cycles.
// Cancel ends the pour early and leaves remaining at its current value.
module water_dispense_controller
  import water_dispense_controller_pkg::*;
#(
  parameter int AMOUNT_WIDTH    = 32,
  parameter int MAX_AMOUNT      = DEFAULT_MAX_AMOUNT,
  parameter int CYCLES_PER_UNIT = 50,
  parameter int SETTLE_CYCLES   = 2
) (
  input logic clock,
  input logic reset,
  water_dispense_controller_if.slave bus
);
  localparam int TW =
    $clog2(max_int(CYCLES_PER_UNIT, SETTLE_CYCLES) + 1);
  localparam logic [AMOUNT_WIDTH-1:0] MAX_A =
    AMOUNT_WIDTH'(MAX_AMOUNT);
  localparam logic [TW-1:0] UNIT_INIT =
    TW'(CYCLES_PER_UNIT - 1);
  localparam logic [TW-1:0] SETTLE_INIT =
    TW'(SETTLE_CYCLES - 1);

  state_t                  state, state_n;
  logic [AMOUNT_WIDTH-1:0] remaining, remaining_n;
  logic                    aborted, aborted_n;
  logic                    valve, valve_n;
  logic                    t_load, t_clear, t_tc;
  logic [TW-1:0]           t_value;

  dispense_unit_timer #(.WIDTH(TW)) timer (
    .clock (clock),
    .reset (reset),
    .load  (t_load),
    .clear (t_clear),
    .value (t_value),
    .tc    (t_tc)
  );

  // state and output registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      remaining <= '0;
      aborted   <= 1'b0;
      valve     <= 1'b0;
    end else begin
      state     <= state_n;
      remaining <= remaining_n;
      aborted   <= aborted_n;
      valve     <= valve_n;
    end
  end

  // next-state, counters and timer control
  always_comb begin
    state_n     = state;
    remaining_n = remaining;
    aborted_n   = aborted;
    valve_n     = valve;
    t_load      = 1'b0;
    t_clear     = 1'b0;
    t_value     = '0;
    unique case (state)
      IDLE: begin
        if (bus.start && !bus.cancel) begin
          aborted_n = 1'b0;
          if (bus.amount != '0) begin
            remaining_n = (bus.amount > MAX_A) ? MAX_A
                                               : bus.amount;
            valve_n = 1'b1;
            t_load  = 1'b1;
            t_value = SETTLE_INIT;
            state_n = SETTLE;
          end else begin
            remaining_n = '0;
            state_n     = FINISH;
          end
        end
      end
      SETTLE: begin
        if (bus.cancel) begin
          valve_n   = 1'b0;
          aborted_n = 1'b1;
          t_clear   = 1'b1;
          state_n   = FINISH;
        end else if (t_tc) begin
          t_load  = 1'b1;
          t_value = UNIT_INIT;
          state_n = POUR;
        end
      end
      POUR: begin
        if (bus.cancel) begin
          valve_n   = 1'b0;
          aborted_n = 1'b1;
          t_clear   = 1'b1;
          state_n   = FINISH;
        end else if (t_tc) begin
          if (remaining > AMOUNT_WIDTH'(1)) begin
            remaining_n = remaining - 1'b1;
            t_load      = 1'b1;
            t_value     = UNIT_INIT;
          end else begin
            remaining_n = '0;
            valve_n     = 1'b0;
            t_clear     = 1'b1;
            state_n     = FINISH;
          end
        end
      end
      FINISH: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign bus.valve_open = valve;
  assign bus.busy       = (state != IDLE);
  assign bus.done       = (state == FINISH);
  assign bus.remaining  = remaining;
  assign bus.aborted    = aborted;
endmodule

// File: tb/tb_water_dispense_controller.sv
// Directed bench for water_dispense_controller.
// Table of per-cycle vectors plus hand sequences for corner cases.
module tb_water_dispense_controller;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clock = ~clock;

  water_dispense_controller_if #(.AMOUNT_WIDTH(32)) bus ();

  water_dispense_controller #(
    .AMOUNT_WIDTH    (32),
    .MAX_AMOUNT      (99),
    .CYCLES_PER_UNIT (4),
    .SETTLE_CYCLES   (2)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic        start;
    logic        cancel;
    logic [31:0] amount;
    logic        valve;
    logic        busy;
    logic        done;
    logic        aborted;
    logic [31:0] rem;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(
    input logic s, input logic c, input int a,
    input logic v, input logic b, input logic d,
    input logic ab, input int r);
    vec_t x;
    x.start = s; x.cancel = c; x.amount = a;
    x.valve = v; x.busy = b; x.done = d;
    x.aborted = ab; x.rem = r;
    return x;
  endfunction

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic s, input logic c,
                       input int a);
    bus.start  = s;
    bus.cancel = c;
    bus.amount = a;
  endtask

  task automatic outs(input string tag, input logic v,
                      input logic b, input logic d,
                      input logic ab, input int r);
    check({tag, ".valve"}, 32'(bus.valve_open), 32'(v));
    check({tag, ".busy"}, 32'(bus.busy), 32'(b));
    check({tag, ".done"}, 32'(bus.done), 32'(d));
    check({tag, ".aborted"}, 32'(bus.aborted), 32'(ab));
    check({tag, ".rem"}, bus.remaining, 32'(r));
  endtask

  task automatic run_pour(input string tag, input int a,
                          input int exp_cycles);
    int cnt;
    int guard;
    drive(1, 0, a);
    tick();
    drive(0, 0, 0);
    check({tag, ".aborted_clr"}, 32'(bus.aborted), 0);
    cnt = 0;
    guard = 0;
    while (bus.valve_open && guard < 1000) begin
      cnt++;
      guard++;
      tick();
    end
    check({tag, ".valve_cycles"}, cnt, exp_cycles);
    check({tag, ".done"}, 32'(bus.done), 1);
    check({tag, ".rem_end"}, bus.remaining, 0);
    tick();
    check({tag, ".busy_off"}, 32'(bus.busy), 0);
    check({tag, ".done_off"}, 32'(bus.done), 0);
  endtask

  initial begin
    drive(0, 0, 0);
    tick();
    tick();
    outs("reset", 0, 0, 0, 0, 0);
    reset = 1'b0;

    tv.push_back(mk(1, 0, 3, 1, 1, 0, 0, 3));
    for (int i = 1; i <= 5; i++)
      tv.push_back(mk(0, 0, 0, 1, 1, 0, 0, 3));
    for (int i = 6; i <= 9; i++)
      tv.push_back(mk(0, 0, 0, 1, 1, 0, 0, 2));
    for (int i = 10; i <= 13; i++)
      tv.push_back(mk(0, 0, 0, 1, 1, 0, 0, 1));
    tv.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
    tv.push_back(mk(1, 0, 0, 0, 1, 1, 0, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
    tv.push_back(mk(1, 1, 5, 0, 0, 0, 0, 0));
    tv.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));

    for (int i = 0; i < tv.size(); i++) begin
      drive(tv[i].start, tv[i].cancel, int'(tv[i].amount));
      tick();
      outs($sformatf("vec%0d", i), tv[i].valve, tv[i].busy,
           tv[i].done, tv[i].aborted, int'(tv[i].rem));
    end

    drive(1, 0, 5);
    tick();
    drive(0, 0, 0);
    for (int i = 1; i <= 8; i++) tick();
    outs("cx.pre", 1, 1, 0, 0, 4);
    drive(0, 1, 0);
    tick();
    drive(0, 0, 0);
    outs("cx.cancel", 0, 1, 1, 1, 4);
    tick();
    outs("cx.idle", 0, 0, 0, 1, 4);
    run_pour("cx.next", 1, 6);

    drive(1, 0, 150);
    tick();
    outs("clamp.latch", 1, 1, 0, 0, 99);
    drive(0, 0, 0);
    for (int i = 1; i <= 3; i++) tick();
    drive(1, 0, 7);
    tick();
    drive(0, 0, 0);
    outs("clamp.restart", 1, 1, 0, 0, 99);
    tick();
    tick();
    outs("clamp.dec", 1, 1, 0, 0, 98);
    drive(0, 1, 0);
    tick();
    drive(0, 0, 0);
    outs("clamp.cancel", 0, 1, 1, 1, 98);
    tick();

    drive(1, 0, 3);
    tick();
    drive(0, 0, 0);
    for (int i = 1; i <= 9; i++) tick();
    outs("tc.pre", 1, 1, 0, 0, 2);
    drive(0, 1, 0);
    tick();
    drive(0, 0, 0);
    outs("tc.cancel", 0, 1, 1, 1, 2);
    tick();
    outs("tc.idle", 0, 0, 0, 1, 2);
    drive(1, 1, 6);
    tick();
    drive(0, 0, 0);
    outs("tc.both", 0, 0, 0, 1, 2);

    drive(1, 0, 3);
    tick();
    drive(0, 0, 0);
    for (int i = 1; i <= 4; i++) tick();
    outs("rst.pre", 1, 1, 0, 0, 3);
    reset = 1'b1;
    #1;
    outs("rst.async", 0, 0, 0, 0, 0);
    tick();
    reset = 1'b0;
    tick();
    outs("rst.after", 0, 0, 0, 0, 0);
    run_pour("rst.pour", 2, 10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
